// File: rtl/reqc_s_ctrl.sv
// reqc_s_ctrl: two-requester round-robin front end for a 4-entry request buffer RAM.
// Buffer is a circular FIFO; the RAM registers ram_radr, so the address is driven one cycle ahead.
module reqc_s_ctrl #(
    parameter int DW      = 36,
    parameter int AW      = 2,
    parameter bit RR_INIT = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_id,
    input  logic          out_ready,
    input  logic          flush,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          ram_wen,
    output logic [AW-1:0] ram_wadr,
    output logic [DW-1:0] ram_wdata,
    output logic [AW-1:0] ram_radr,
    input  logic [DW-1:0] ram_rdata
);
    localparam int DEPTH = 1 << AW;

    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic [DEPTH-1:0] id_q, id_d;
    logic             prio_q, prio_d;
    logic             can, g0, g1, push, pop;

    always_comb begin
        full       = count_q == (AW+1)'(DEPTH);
        empty      = count_q == '0;
        // rst_n gates the grant so readies drop the instant reset asserts
        can        = rst_n && !flush && !full;
        g0         = can && req0_valid && (!req1_valid || !prio_q);
        g1         = can && req1_valid && (!req0_valid || prio_q);
        push       = g0 || g1;
        out_valid  = !empty && !flush;
        pop        = out_valid && out_ready;
        req0_ready = g0;
        req1_ready = g1;
        ram_wen    = push;
        ram_wadr   = wptr_q;
        ram_wdata  = g1 ? req1_data : req0_data;
        wptr_d     = flush ? '0 : wptr_q + AW'(push);
        rptr_d     = flush ? '0 : rptr_q + AW'(pop);
        count_d    = flush ? '0 :
                     (push && !pop) ? count_q + (AW+1)'(1) :
                     (pop && !push) ? count_q - (AW+1)'(1) : count_q;
        prio_d     = push ? g0 : prio_q;
        id_d       = id_q;
        if (push) id_d[wptr_q] = g1;
        ram_radr   = rptr_d;
        out_data   = ram_rdata;
        out_id     = id_q[rptr_q];
        count      = count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            id_q    <= '0;
            prio_q  <= RR_INIT;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            id_q    <= id_d;
            prio_q  <= prio_d;
        end
    end
endmodule

// File: tb/tb_reqc_s_ctrl.sv
// tb_reqc_s_ctrl: scenario tasks plus a randomized run against a queue-based model of the buffer.
module tb_reqc_s_ctrl;
    localparam int DW = 36;
    localparam int AW = 2;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [DW-1:0] req0_data = '0, req1_data = '0, ram_rdata;
    logic          req0_ready, req1_ready, out_valid, out_id, full, empty, ram_wen;
    logic [DW-1:0] out_data, ram_wdata;
    logic [AW:0]   count;
    logic [AW-1:0] ram_wadr, ram_radr;
    logic [DW-1:0] mem [4];

    always #5 clk = ~clk;

    reqc_s_ctrl #(.DW(DW), .AW(AW), .RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_ready(out_ready),
        .flush(flush), .count(count), .full(full), .empty(empty),
        .ram_wen(ram_wen), .ram_wadr(ram_wadr), .ram_wdata(ram_wdata),
        .ram_radr(ram_radr), .ram_rdata(ram_rdata)
    );

    // Buffer RAM: registered read, write-first on an address collision
    always @(posedge clk) begin
        if (ram_wen) mem[ram_wadr] <= ram_wdata;
        ram_rdata <= (ram_wen && ram_wadr == ram_radr) ? ram_wdata : mem[ram_radr];
    end

    typedef struct packed {logic id; logic [DW-1:0] d;} ent_t;
    ent_t          mq[$];
    int            mw, mr, e_cnt, e_radr;
    bit            mp, e_r0, e_r1, e_ov, e_pop, e_oid;
    logic [DW-1:0] e_od;
    int            total = 0, passed = 0;

    task automatic model_eval();
        bit cn;
        cn     = !flush && mq.size() < 4;
        e_r0   = cn && req0_valid && (!req1_valid || !mp);
        e_r1   = cn && req1_valid && (!req0_valid || mp);
        e_ov   = mq.size() > 0 && !flush;
        e_pop  = e_ov && out_ready;
        e_cnt  = mq.size();
        e_radr = flush ? 0 : (mr + (e_pop ? 1 : 0)) % 4;
        if (e_ov) begin
            e_od  = mq[0].d;
            e_oid = mq[0].id;
        end
    endtask

    task automatic model_commit();
        if (flush) begin
            mq.delete();
            mw = 0;
            mr = 0;
        end else begin
            if (e_pop) begin
                void'(mq.pop_front());
                mr = (mr + 1) % 4;
            end
            if (e_r0 || e_r1) begin
                mq.push_back('{e_r1, e_r1 ? req1_data : req0_data});
                mw = (mw + 1) % 4;
                mp = e_r1 ? 1'b0 : 1'b1;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req0_valid = 0; req1_valid = 0; out_ready = 0; flush = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        mw = 0; mr = 0; mp = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; req0_valid = 1; req1_valid = 1; out_ready = 1;
        #3;
        total++;
        if ({req0_ready, req1_ready, out_valid, ram_wen, full, empty, out_id} !== 7'b0000010)
            $display("FAIL reset_ctrl: got %b want 0000010",
                     {req0_ready, req1_ready, out_valid, ram_wen, full, empty, out_id});
        else passed++;
        total++;
        if ({count, ram_wadr, ram_radr} !== 7'd0)
            $display("FAIL reset_ptrs: got cnt=%0d wadr=%0d radr=%0d want 0", count, ram_wadr, ram_radr);
        else passed++;
        do_reset();
    endtask

    task automatic test_single_push();
        req0_valid = 1; req0_data = 36'h1; out_ready = 0;
        settle();
        total++;
        if ({req0_ready, req1_ready, ram_wen, ram_wadr, ram_wdata} !== {3'b101, 2'd0, 36'h1})
            $display("FAIL single_push: got r0=%b r1=%b wen=%b wadr=%0d wdata=%h want 1 0 1 0 1",
                     req0_ready, req1_ready, ram_wen, ram_wadr, ram_wdata);
        else passed++;
        advance();
        req0_valid = 0;
        settle();
        total++;
        if ({out_valid, out_id, out_data, count} !== {2'b10, 36'h1, 3'd1})
            $display("FAIL single_out: got v=%b id=%b d=%h cnt=%0d want 1 0 1 1",
                     out_valid, out_id, out_data, count);
        else passed++;
        advance();
    endtask

    task automatic test_fill_rr();
        do_reset();
        req0_valid = 1; req1_valid = 1; out_ready = 0;
        for (int i = 0; i < 6; i++) begin
            req0_data = DW'({$urandom(), $urandom()});
            req1_data = DW'({$urandom(), $urandom()});
            settle();
            total++;
            if ({req0_ready, req1_ready, full} !== (i < 4 ? {(i % 2 == 0), (i % 2 == 1), 1'b0} : 3'b001))
                $display("FAIL fill_grant[%0d]: got r0=%b r1=%b full=%b", i, req0_ready, req1_ready, full);
            else passed++;
            advance();
        end
        idle_in();
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            total++;
            if ({out_valid, out_id, out_data} !== {1'b1, i[0], e_od})
                $display("FAIL drain[%0d]: got v=%b id=%b d=%h want 1 %0d %h",
                         i, out_valid, out_id, out_data, i % 2, e_od);
            else passed++;
            advance();
        end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1;
        for (int i = 0; i <= 12; i++) begin
            req1_valid = i < 12;
            req1_data  = DW'(i + 1);
            settle();
            total++;
            if (i < 12 && {req1_ready, ram_wadr} !== {1'b1, 2'(i % 4)})
                $display("FAIL stream_push[%0d]: got rdy=%b wadr=%0d want 1 %0d", i, req1_ready, ram_wadr, i % 4);
            else if (i > 0 && {out_valid, out_id, out_data, count} !== {2'b11, DW'(i), 3'd1})
                $display("FAIL stream_pop[%0d]: got v=%b id=%b d=%h cnt=%0d want 1 1 %h 1",
                         i, out_valid, out_id, out_data, count, i);
            else passed++;
            advance();
        end
        idle_in();
    endtask

    task automatic test_full_pop();
        do_reset();
        req0_valid = 1;
        for (int i = 0; i < 4; i++) begin
            req0_data = DW'(i + 16);
            settle();
            advance();
        end
        out_ready = 1;
        req0_data = 36'h55;
        settle();
        total++;
        if ({req0_ready, full, out_valid, out_data} !== {3'b011, 36'h10})
            $display("FAIL full_pop: got rdy=%b full=%b v=%b d=%h want 0 1 1 10",
                     req0_ready, full, out_valid, out_data);
        else passed++;
        advance();
        settle();
        total++;
        if ({req0_ready, count, full} !== {1'b1, 3'd3, 1'b0})
            $display("FAIL after_pop: got rdy=%b cnt=%0d full=%b want 1 3 0", req0_ready, count, full);
        else passed++;
        advance();
        idle_in();
    endtask

    task automatic test_flush();
        do_reset();
        req0_valid = 1;
        for (int i = 0; i < 3; i++) begin
            req0_data = DW'($urandom());
            settle();
            advance();
        end
        flush = 1; out_ready = 1;
        settle();
        total++;
        if ({req0_ready, req1_ready, out_valid, ram_radr} !== 5'd0)
            $display("FAIL flush_cycle: got r0=%b r1=%b v=%b radr=%0d want 0", req0_ready, req1_ready, out_valid, ram_radr);
        else passed++;
        advance();
        flush = 0; out_ready = 0; req0_data = 36'hABC;
        settle();
        total++;
        if ({count, empty, req0_ready, ram_radr, ram_wadr} !== {3'd0, 2'b11, 4'd0})
            $display("FAIL post_flush: got cnt=%0d e=%b rdy=%b radr=%0d wadr=%0d want 0 1 1 0 0",
                     count, empty, req0_ready, ram_radr, ram_wadr);
        else passed++;
        advance();
        req0_valid = 0;
        settle();
        total++;
        if ({out_valid, out_data, count} !== {1'b1, 36'hABC, 3'd1})
            $display("FAIL flush_push: got v=%b d=%h cnt=%0d want 1 abc 1", out_valid, out_data, count);
        else passed++;
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req0_valid = $urandom_range(0, 3) != 0;
            req1_valid = $urandom_range(0, 2) != 0;
            req0_data  = DW'({$urandom(), $urandom()});
            req1_data  = DW'({$urandom(), $urandom()});
            out_ready  = $urandom_range(0, 2) != 0;
            flush      = $urandom_range(0, 19) == 0;
            settle();
            total++;
            if ({req0_ready, req1_ready, out_valid, count, full, empty, ram_wen, ram_radr} !==
                {e_r0, e_r1, e_ov, 3'(e_cnt), e_cnt == 4, e_cnt == 0, e_r0 | e_r1, 2'(e_radr)})
                $display("FAIL rand_ctrl[%0d]: got r=%b%b v=%b cnt=%0d wen=%b radr=%0d want r=%b%b v=%b cnt=%0d radr=%0d",
                         i, req0_ready, req1_ready, out_valid, count, ram_wen, ram_radr,
                         e_r0, e_r1, e_ov, e_cnt, e_radr);
            else passed++;
            if (e_ov) begin
                total++;
                if ({out_id, out_data} !== {e_oid, e_od})
                    $display("FAIL rand_data[%0d]: got id=%b d=%h want id=%b d=%h", i, out_id, out_data, e_oid, e_od);
                else passed++;
            end
            if (e_r0 || e_r1) begin
                total++;
                if ({ram_wadr, ram_wdata} !== {2'(mw), e_r1 ? req1_data : req0_data})
                    $display("FAIL rand_wr[%0d]: got wadr=%0d wdata=%h want wadr=%0d", i, ram_wadr, ram_wdata, mw);
                else passed++;
            end
            advance();
        end
        idle_in();
    endtask

    task automatic test_async_reset();
        do_reset();
        req0_valid = 1; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            req0_data = DW'($urandom());
            settle();
            advance();
        end
        #2;
        rst_n = 0;
        #1;
        total++;
        if ({out_valid, count, req0_ready, req1_ready, empty} !== {1'b0, 3'd0, 3'b001})
            $display("FAIL async_rst: got v=%b cnt=%0d r0=%b r1=%b e=%b want 0 0 0 0 1",
                     out_valid, count, req0_ready, req1_ready, empty);
        else passed++;
        idle_in();
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        test_single_push();
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_rr();
        test_stream();
        test_full_pop();
        test_flush();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/reqc_s_ctrl.md
Name: reqc_s_ctrl

Overview:
- Controller for the 4-entry x 36-bit 1r1w request buffer RAM in the AXI arbiter path.
- Arbitrates between two requesters (round-robin) writing request words into the shared buffer.
- Sequences buffer RAM read/write addresses as a circular FIFO.
- Presents queued words on a valid/ready output together with the originating requester ID.

Parameters:
DW, 36, request word width; must equal the buffer RAM data width.
AW, 2, buffer address width; depth = 2**AW = 4 entries.
RR_INIT, 0, requester that holds priority after reset (0 or 1).

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a word
req0_data  in  DW  requester 0 word
req0_ready  out  1  requester 0 word accepted this cycle when valid&ready
req1_valid  in  1  requester 1 has a word
req1_data  in  DW  requester 1 word
req1_ready  out  1  requester 1 word accepted this cycle when valid&ready
out_valid  out  1  head entry available
out_data  out  DW  head entry word (= ram_rdata)
out_id  out  1  requester that wrote the head entry
out_ready  in  1  consumer takes head when out_valid&out_ready
flush  in  1  synchronous queue clear
count  out  AW+1  occupancy 0..4
full  out  1  count==4
empty  out  1  count==0
ram_wen  out  1  buffer RAM write enable
ram_wadr  out  AW  buffer RAM write address
ram_wdata  out  DW  buffer RAM write data
ram_radr  out  AW  buffer RAM read address (RAM registers it; ram_rdata valid next cycle)
ram_rdata  in  DW  buffer RAM read data

Behaviour:
- Reset (rst_n=0, async): wptr=0, rptr=0, count=0, id flags=0, priority=RR_INIT. Outputs: req*_ready=0, out_valid=0, out_id=0, ram_wen=0, ram_wadr=0, ram_radr=0, full=0, empty=1. out_data follows ram_rdata (undefined until the first write).
- Arbitration (combinational, same cycle):
  - Grant only if !full && !flush.
  - Both valid: grant the priority holder. One valid: grant it. None: no grant.
  - reqN_ready = grant==N; at most one ready high per cycle.
  - ready never depends on out_ready: no push into a full queue even if a pop happens that cycle.
- Push (valid&ready):
  - ram_wen=1, ram_wadr=wptr, ram_wdata=granted data.
  - idflag[wptr] <= granted id; wptr <= wptr+1 (mod 4, natural wrap).
  - Priority <= other requester after any grant; unchanged when there is no grant.
- Pop (out_valid&out_ready): rptr <= rptr+1 (mod 4).
- Read sequencing:
  - ram_radr is driven with next-cycle rptr (rptr+1 on pop, else rptr; 0 on flush).
  - This makes ram_rdata = entry[rptr] every cycle.
  - out_data = ram_rdata; out_id = idflag[rptr].
  - Push-to-out_valid latency is 1 cycle: written at edge t, visible and valid in cycle t+1.
- count:
  - push&!pop: +1. pop&!push: -1. Both: unchanged. Never exceeds 4 or goes below 0.
  - full/empty are decoded from registered count.
- out_valid = !empty && !flush.
- flush=1:
  - No push, no pop.
  - Next edge: wptr=rptr=0, count=0, ram_radr=0.
  - Priority is kept; id flags need not be cleared.
- Simultaneous push and pop when count==1 and wptr!=rptr: legal. Pop takes the old head, the new word is queued behind it, count stays 1.
- Data ordering: strict FIFO across both requesters, in grant order.
- Reset asserted mid-operation: queue contents are discarded immediately and all outputs go to their reset values asynchronously.

Test Plan:
- Reset, then req0 pushes 0x000000001 with out_ready=0 -> req0_ready=1 that cycle; next cycle out_valid=1, out_data=0x000000001, out_id=0, count=1.
- Both requesters valid continuously, out_ready=0, RR_INIT=0 -> grants 0,1,0,1 fill 4 entries; full=1 and both readies 0 from cycle 5. Then out_ready=1 -> out_id sequence 0,1,0,1 with data in push order.
- Streaming: req1 valid every cycle, out_ready=1 -> one push and one pop per cycle after a 1-cycle fill. count stays 1; pointers wrap 3->0 with no data loss over 12 words (0x1..0xC in order).
- Full plus pop same cycle: queue full, out_ready=1, req0_valid=1 -> req0_ready=0 that cycle; next cycle count=3 and req0 is accepted.
- Flush with 3 entries queued -> out_valid=0 and readies 0 during the flush cycle; next cycle count=0, empty=1. The next push of 0xABC appears at out_data with ram_radr=0.
- Async reset asserted mid-stream between clock edges -> out_valid=0, count=0, ready=0 immediately; after release, behaviour matches post-reset case 1.
